// File: rtl/res_dump_if.sv
// RAM read port and pixel stream bundle for the result-RAM dump engine.
interface res_dump_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 8
) ();
  logic              res_rd;
  logic              res_wr;
  logic [ADDR_W-1:0] res_addr;
  logic [DATA_W-1:0] res_di;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;

  // Dump engine side: drives the RAM read port and the pixel stream.
  modport master (
    output res_rd, res_wr, res_addr,
    input  res_di,
    output out_valid, out_data, out_addr,
    input  out_ready
  );

  // RAM / sink side.
  modport slave (
    input  res_rd, res_wr, res_addr,
    output res_di,
    input  out_valid, out_data, out_addr,
    output out_ready
  );
endinterface

// File: rtl/res_dump.sv
// Result-RAM read-back engine: reads every pixel in ascending order, streams
// {addr, data} over a valid/ready byte port through a 2-entry FIFO, and
// accumulates a checksum and a nonzero-pixel count over the accepted beats.
module res_dump #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_PIX  = 16384,
  parameter int unsigned SUM_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  res_dump_if.master       bus,
  output logic             busy,
  output logic             dump_done,
  output logic [SUM_W-1:0] checksum,
  output logic [ADDR_W:0]  nz_count
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, FIN} state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   NZ_ONE    = (ADDR_W + 1)'(1);

  state_e            state_q;
  logic              busy_q;
  logic              done_q;
  logic              rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] acc_cnt_q;
  logic [SUM_W-1:0]  sum_q;
  logic [ADDR_W:0]   nz_q;

  // FIFO head (drives the stream outputs directly) and second slot.
  logic              o_vld_q;
  logic [ADDR_W-1:0] o_addr_q;
  logic [DATA_W-1:0] o_data_q;
  logic              b_vld_q;
  logic [ADDR_W-1:0] b_addr_q;
  logic [DATA_W-1:0] b_data_q;

  logic              pop;
  logic              push;
  logic [1:0]        occ_d;
  logic              can_issue;
  logic [ADDR_W-1:0] addr_d;

  // Handshake decode and read-issue permission.
  // occ_d is the occupancy after this edge (capture in, accept out); a new
  // read keeps occ_d + 1 outstanding <= 2, which still allows 1 pixel/clk.
  always_comb begin
    pop       = o_vld_q & bus.out_ready;
    push      = rd_q;
    occ_d     = 2'({1'b0, o_vld_q}) + 2'({1'b0, b_vld_q})
              + 2'({1'b0, push}) - 2'({1'b0, pop});
    can_issue = (occ_d < 2'd2);
    addr_d    = addr_q + ADDR_ONE;
  end

  // FIFO, accumulators and control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      acc_cnt_q <= '0;
      sum_q     <= '0;
      nz_q      <= '0;
      o_vld_q   <= 1'b0;
      o_addr_q  <= '0;
      o_data_q  <= '0;
      b_vld_q   <= 1'b0;
      b_addr_q  <= '0;
      b_data_q  <= '0;
    end else begin
      // FIFO: capture of the read issued last cycle, accept at the head.
      if (pop) begin
        if (b_vld_q) begin
          o_addr_q <= b_addr_q;
          o_data_q <= b_data_q;
          if (push) begin
            b_addr_q <= addr_q;
            b_data_q <= bus.res_di;
          end else begin
            b_vld_q <= 1'b0;
          end
        end else if (push) begin
          o_addr_q <= addr_q;
          o_data_q <= bus.res_di;
        end else begin
          o_vld_q <= 1'b0;
        end
      end else if (push) begin
        if (!o_vld_q) begin
          o_vld_q  <= 1'b1;
          o_addr_q <= addr_q;
          o_data_q <= bus.res_di;
        end else begin
          b_vld_q  <= 1'b1;
          b_addr_q <= addr_q;
          b_data_q <= bus.res_di;
        end
      end

      // Accumulate over accepted beats.
      if (pop) begin
        sum_q     <= sum_q + SUM_W'(o_data_q);
        acc_cnt_q <= acc_cnt_q + ADDR_ONE;
        if (o_data_q != '0) begin
          nz_q <= nz_q + NZ_ONE;
        end
      end

      done_q <= 1'b0;
      rd_q   <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= (LAST_ADDR == '0) ? FLUSH : RUN;
            busy_q    <= 1'b1;
            sum_q     <= '0;
            nz_q      <= '0;
            acc_cnt_q <= '0;
            rd_q      <= 1'b1;
            addr_q    <= '0;
          end
        end
        RUN: begin
          if (can_issue) begin
            rd_q   <= 1'b1;
            addr_q <= addr_d;
            if (addr_d == LAST_ADDR) begin
              state_q <= FLUSH;
            end
          end
        end
        FLUSH: begin
          // The last accept also means the FIFO and read pipe are empty.
          if (pop && (acc_cnt_q == LAST_ADDR)) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.res_rd    = rd_q;
  assign bus.res_wr    = 1'b0;
  assign bus.res_addr  = addr_q;
  assign bus.out_valid = o_vld_q;
  assign bus.out_data  = o_data_q;
  assign bus.out_addr  = o_addr_q;
  assign busy          = busy_q;
  assign dump_done     = done_q;
  assign checksum      = sum_q;
  assign nz_count      = nz_q;

endmodule

// File: tb/tb_res_dump.sv
// Bench for res_dump: RAM model, stream monitor and table-driven dump runs
// plus directed stall, reset and restart sequences.
module tb_res_dump;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int N_PIX  = 16384;
  localparam int SUM_W  = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             busy;
  logic             dump_done;
  logic [SUM_W-1:0] checksum;
  logic [ADDR_W:0]  nz_count;

  res_dump_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  res_dump #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_PIX(N_PIX), .SUM_W(SUM_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus.master),
    .busy      (busy),
    .dump_done (dump_done),
    .checksum  (checksum),
    .nz_count  (nz_count)
  );

  always #5 clk = ~clk;

  // Result RAM: samples address at negedge, data valid at next posedge.
  logic [DATA_W-1:0] mem [N_PIX];
  always @(negedge clk) begin
    if (bus.res_rd) bus.res_di <= mem[bus.res_addr];
  end

  // Stream monitor state (written only by the monitor process).
  int issued, accepted, stream_err, first_err_addr, done_pulses, done_err, max_out;
  logic prev_last, hold;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;

  always @(negedge clk) begin
    if (reset || (start && !busy)) begin
      issued = 0; accepted = 0; stream_err = 0; first_err_addr = -1;
      done_pulses = 0; done_err = 0; max_out = 0; prev_last = 1'b0; hold = 1'b0;
    end else begin
      if (bus.res_rd) begin
        if (bus.res_addr != ADDR_W'(issued)) begin
          if (stream_err == 0) first_err_addr = int'(bus.res_addr);
          stream_err++;
        end
        issued++;
      end
      if (issued - accepted > max_out) max_out = issued - accepted;
      if (dump_done) begin
        done_pulses++;
        if (!prev_last) done_err++;
      end
      if (hold && (!bus.out_valid || bus.out_addr != hold_addr || bus.out_data != hold_data)) begin
        if (stream_err == 0) first_err_addr = int'(hold_addr);
        stream_err++;
      end
      prev_last = 1'b0;
      hold      = 1'b0;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          if (accepted >= N_PIX || bus.out_addr != ADDR_W'(accepted) ||
              bus.out_data != mem[accepted % N_PIX]) begin
            if (stream_err == 0) first_err_addr = int'(bus.out_addr);
            stream_err++;
          end
          prev_last = (accepted == N_PIX - 1);
          accepted++;
        end else begin
          hold      = 1'b1;
          hold_addr = bus.out_addr;
          hold_data = bus.out_data;
        end
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic load_img(input int kind);
    for (int i = 0; i < N_PIX; i++) begin
      int v;
      case (kind)
        0:       v = 0;
        1:       v = i;
        default: v = i * 7 + 3;
      endcase
      mem[i] = v[7:0];
    end
  endtask

  function automatic int ref_sum();
    int s = 0;
    for (int i = 0; i < N_PIX; i++) s = (s + int'(mem[i])) % 65536;
    return s;
  endfunction

  function automatic int ref_nz();
    int n = 0;
    for (int i = 0; i < N_PIX; i++) if (mem[i] != 0) n++;
    return n;
  endfunction

  // Pulse start from IDLE and check the first two cycles of latency.
  task automatic start_dump(input logic [3:0] rdy);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bus.out_ready = rdy[0];
    check("busy_after_start", busy, 1);
    check("first_rd", bus.res_rd, 1);
    check("first_addr", bus.res_addr, 0);
    check("valid_too_early", bus.out_valid, 0);
    @(posedge clk); #1;
    bus.out_ready = rdy[1];
    check("first_valid", bus.out_valid, 1);
    check("first_out_addr", bus.out_addr, 0);
  endtask

  task automatic drive_until_done(input logic [3:0] rdy, input int phase, input int budget,
                                  output int cycles);
    cycles = 0;
    while (done_pulses == 0 && cycles < budget) begin
      @(posedge clk); #1;
      bus.out_ready = rdy[(cycles + phase) % 4];
      cycles++;
    end
    check("dump_done_within_budget", (done_pulses != 0) ? 1 : 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic post_checks(input int exp_sum, input int exp_nz);
    check("dump_done_pulses", done_pulses, 1);
    check("dump_done_not_after_last", done_err, 0);
    check("beats_accepted", accepted, N_PIX);
    check("reads_issued", issued, N_PIX);
    if (stream_err != 0) $display("  first stream error near addr %0d", first_err_addr);
    check("stream_errs", stream_err, 0);
    check("max_outstanding", max_out, 2);
    check("checksum", checksum, exp_sum);
    check("nz_count", nz_count, exp_nz);
    check("busy_idle", busy, 0);
  endtask

  typedef struct {
    int         img;
    logic [3:0] rdy;
    int         exp_sum;
    int         exp_nz;
    int         exp_cycles;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int cyc;

    vecs[0] = '{img: 0, rdy: 4'b1111, exp_sum: 0,       exp_nz: 0,     exp_cycles: N_PIX + 1};
    vecs[1] = '{img: 1, rdy: 4'b1111, exp_sum: 'hE000,  exp_nz: 16320, exp_cycles: N_PIX + 1};
    vecs[2] = '{img: 1, rdy: 4'b1001, exp_sum: 'hE000,  exp_nz: 16320, exp_cycles: 0};

    reset = 1'b1;
    start = 1'b0;
    bus.out_ready = 1'b0;
    load_img(0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_rd", bus.res_rd, 0);
    check("rst_wr", bus.res_wr, 0);
    check("rst_addr", bus.res_addr, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_addr", bus.out_addr, 0);
    check("rst_done", dump_done, 0);
    check("rst_checksum", checksum, 0);
    check("rst_nz", nz_count, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset mid-dump at beat 100, with start asserted alongside reset.
    load_img(1);
    start_dump(4'b1111);
    cyc = 0;
    while (accepted < 100 && cyc < 300) begin
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      cyc++;
    end
    check("reached_beat_100", (accepted >= 100) ? 1 : 0, 1);
    check("checksum_midrun_nonzero", (checksum != 0) ? 1 : 0, 1);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_checksum", checksum, 0);
    check("midrst_nz", nz_count, 0);
    check("midrst_rd", bus.res_rd, 0);
    reset = 1'b0;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_stays_idle", busy, 0);
    check("midrst_no_done", done_pulses, 0);

    // Table-driven full dumps.
    for (int v = 0; v < 3; v++) begin
      load_img(vecs[v].img);
      start_dump(vecs[v].rdy);
      drive_until_done(vecs[v].rdy, 2, 40000, cyc);
      if (vecs[v].exp_cycles != 0) check("full_rate_cycles", cyc, vecs[v].exp_cycles);
      post_checks(vecs[v].exp_sum, vecs[v].exp_nz);
    end

    // Sink stalled for 50 cycles, then released; start re-pulsed mid-dump.
    load_img(2);
    start_dump(4'b0000);
    repeat (48) @(posedge clk);
    #1;
    check("stall_reads_issued", issued, 2);
    check("stall_rd_low", bus.res_rd, 0);
    check("stall_valid_held", bus.out_valid, 1);
    check("stall_addr_held", bus.out_addr, 0);
    check("stall_data_held", bus.out_data, 3);
    bus.out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_ignored_busy", busy, 1);
    drive_until_done(4'b1111, 0, 20000, cyc);
    post_checks(ref_sum(), ref_nz());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
